// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// Each multiply or divide retires one bit per clock, then passes through a
// sign-fix state and a commit state before HI/LO are updated.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, FIN} state_t;

  state_t             state;
  logic               is_div;
  logic               prod_neg;
  logic               quo_neg;
  logic               rem_neg;
  logic               dz_pend;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   opnd_b;
  logic [2*WIDTH-1:0] acc;

  logic               sgn_op;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;

  // Operand magnitudes and the next shift-add / restoring-divide step.
  always_comb begin
    sgn_op    = ~op[0];
    abs_a     = (sgn_op && a[WIDTH-1]) ? -a : a;
    abs_b     = (sgn_op && b[WIDTH-1]) ? -b : b;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd_b : {WIDTH{1'b0}})};
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd_b};
    if (div_shift >= {1'b0, opnd_b}) begin
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM, datapath registers and the architectural HI/LO registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      count       <= '0;
      is_div      <= 1'b0;
      prod_neg    <= 1'b0;
      quo_neg     <= 1'b0;
      rem_neg     <= 1'b0;
      dz_pend     <= 1'b0;
      opnd_b      <= '0;
      acc         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div      <= op[1];
            opnd_b      <= abs_b;
            prod_neg    <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            quo_neg     <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            rem_neg     <= sgn_op & a[WIDTH-1];
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            if (op[1] && (b == '0)) begin
              dz_pend <= 1'b1;
              acc     <= {a, {WIDTH{1'b1}}};
              count   <= '0;
              state   <= FIX;
            end else begin
              dz_pend <= 1'b0;
              acc     <= {{WIDTH{1'b0}}, abs_a};
              count   <= CNT_W'(WIDTH);
              state   <= RUN;
            end
          end else begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
          end
        end
        RUN: begin
          acc   <= is_div ? div_next : mul_next;
          count <= count - 1'b1;
          if (count == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          if (dz_pend) begin
            div_by_zero <= 1'b1;
          end else if (!is_div) begin
            if (prod_neg) acc <= -acc;
          end else begin
            if (rem_neg) acc[2*WIDTH-1:WIDTH] <= -acc[2*WIDTH-1:WIDTH];
            if (quo_neg) acc[WIDTH-1:0] <= -acc[WIDTH-1:0];
          end
          state <= FIN;
        end
        FIN: begin
          hi    <= acc[2*WIDTH-1:WIDTH];
          lo    <= acc[WIDTH-1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit; successor to the combinational ALU HI/LO path.
- Runs signed/unsigned multiply and divide iteratively, one bit per clock, and owns the architectural HI/LO registers.
- Sits beside the ALU in the execute stage; the pipeline stalls on busy.
- Also supports direct HI/LO writes (move-to-HI/LO).

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO; must be ≥4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only when idle.
- op  input  2  00 signed mult, 01 unsigned mult, 10 signed div, 11 unsigned div.
- a  input  WIDTH  multiplicand / dividend.
- b  input  WIDTH  multiplier / divisor.
- wr_hi  input  1  write wr_data into HI; honoured only when idle.
- wr_lo  input  1  write wr_data into LO; honoured only when idle.
- wr_data  input  WIDTH  data for direct HI/LO writes.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO just updated by an operation.
- div_by_zero  output  1  last completed divide had b==0.
- hi  output  WIDTH  HI register: product upper half / remainder.
- lo  output  WIDTH  LO register: product lower half / quotient.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0. Deassertion takes effect at the next edge.
- Reset mid-operation aborts the operation. HI/LO return to 0 with no done pulse.
- States: IDLE, RUN, FIX, FIN.
- IDLE, start=1 (accept edge):
  - Latch op.
  - Latch |a| and |b| for signed ops; raw a and b for unsigned ops.
  - Record the result signs: product sign = a[MSB]^b[MSB]; quotient sign = a[MSB]^b[MSB]; remainder sign = a[MSB].
  - Clear div_by_zero. Go to RUN with counter=WIDTH. busy=1 from the cycle after the accept edge.
- Divide with b==0 at accept: go straight to FIX and skip iteration.
- RUN: one iteration per edge, counter decrements; leave for FIX when the counter reaches 0 (exactly WIDTH edges).
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per edge.
- FIX, one edge:
  - Apply two's-complement negation per the recorded signs to the internal result only.
  - Divide by zero: result hi=a as latched (raw), lo=all ones; div_by_zero set.
- FIN edge:
  - Commit the result to hi/lo.
  - done=1 for exactly this following cycle; busy=0 in that same cycle.
  - Return to IDLE.
- Latency:
  - Normal: done is high in the cycle after the (WIDTH+2)th edge following the accept edge (34 edges for WIDTH=32).
  - Divide by zero: 2 edges.
- hi/lo change only at the FIN edge, at a direct-write edge, or on reset. They hold otherwise, including throughout RUN.
- Signed divide:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Most-negative ÷ −1 gives lo = most-negative and hi = 0 (natural wrap, no flag).
- Unsigned ops use no sign processing.
- start while busy: ignored, with no queuing.
- start with wr_hi/wr_lo in the same IDLE cycle: start wins and the writes are dropped.
- wr_hi/wr_lo while busy: dropped.
- wr_hi and wr_lo together: both registers take wr_data.
- Direct writes do not pulse done and do not change div_by_zero.
- op, a and b are don't-care except at the accept edge.

Test Plan:
- Reset: reset_n=0 asynchronously mid-RUN (10 edges into a mult) -> immediately busy=0, hi=0, lo=0; after release, done never pulses.
- Signed mult, a=32'hFFFFFFFF (−1), b=32'h7 -> after 34 edges done=1 for one cycle; hi=32'hFFFFFFFF, lo=32'hFFFFFFF9. Same operands with op=01 -> hi=32'h6, lo=32'hFFFFFFF9.
- Signed div, a=−7 (32'hFFFFFFF9), b=2 -> lo=32'hFFFFFFFD (−3), hi=32'hFFFFFFFF (−1). Unsigned div 8/3 -> lo=2, hi=2.
- Divide by zero, op=11, a=32'h5, b=0 -> done 2 edges after accept; hi=5, lo=32'hFFFFFFFF, div_by_zero=1. A subsequent valid div clears div_by_zero at its accept edge.
- Contention:
  - start re-asserted every cycle during busy -> exactly one done per accepted op.
  - wr_lo=1 during busy -> lo unchanged.
  - wr_hi=1, wr_data=32'hABCD0123 while idle -> hi=32'hABCD0123 the next cycle, no done.
- Boundary: signed div 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0. Repeat the mult check with WIDTH=8 -> latency 10 edges.
